csr_bus_arbiter: RTL and testbench

- Shares a single CSR register-file memory port between two requesters: requester 0 is the host bus bridge, requester 1 is the boot-time config loader or debug port.
- CSR port: address, byte strobe, write data, write enable and chip select, with a combinational read-data return and single-cycle writes.
- The arbiter picks one requester round-robin, drives one CSR access and returns read data with an acknowledge pulse.

---
 rtl/csr_bus_arbiter_if.sv | 68 ++++++
 rtl/csr_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_csr_bus_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// csr_bus_arbiter_if
// Bundles the bus signals around the CSR arbiter: two requester ports
// (m0 = host bus bridge, m1 = config loader / debug port), the shared CSR
// memory port, and the arbiter busy flag.
//
//   m0_* / m1_*  : req, addr, strb, wdata, wen from the requester;
//                  ack, rdata back to the requester
//   csr_*        : cs, wen, addr, strb, wdata to the register file;
//                  rdata (combinational) back from it
//   busy         : arbiter is in the middle of an access
//
// Modports:
//   slave  - the arbiter side
//   master - the surrounding system (requesters plus register file)
// ----------------------------------------------------------------------------
interface csr_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);

  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [STRB_WIDTH-1:0] m0_strb;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_wen;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [STRB_WIDTH-1:0] m1_strb;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_wen;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  csr_cs;
  logic                  csr_wen;
  logic [ADDR_WIDTH-1:0] csr_addr;
  logic [STRB_WIDTH-1:0] csr_strb;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic [DATA_WIDTH-1:0] csr_rdata;

  logic                  busy;

  modport slave (
    input  m0_req, m0_addr, m0_strb, m0_wdata, m0_wen,
    output m0_ack, m0_rdata,
    input  m1_req, m1_addr, m1_strb, m1_wdata, m1_wen,
    output m1_ack, m1_rdata,
    output csr_cs, csr_wen, csr_addr, csr_strb, csr_wdata,
    input  csr_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_addr, m0_strb, m0_wdata, m0_wen,
    input  m0_ack, m0_rdata,
    output m1_req, m1_addr, m1_strb, m1_wdata, m1_wen,
    input  m1_ack, m1_rdata,
    input  csr_cs, csr_wen, csr_addr, csr_strb, csr_wdata,
    output csr_rdata,
    input  busy
  );

endinterface

// File: rtl/csr_bus_arbiter.sv
// ----------------------------------------------------------------------------
// csr_bus_arbiter
// Shares one CSR register-file port between two requesters with round-robin
// arbitration. Each access takes three cycles: IDLE (arbitrate and register
// the winner's command), ACCESS (chip select high, read data captured),
// RESP (one-cycle ack to the winner). All outputs come straight from flops.
//
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset
//   bus   - csr_bus_arbiter_if.slave: requester ports m0/m1, CSR port, busy
// ----------------------------------------------------------------------------
module csr_bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input logic               clk,
  input logic               rstn,
  csr_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic                  csr_cs_q, csr_cs_d;
  logic                  csr_wen_q, csr_wen_d;
  logic [ADDR_WIDTH-1:0] csr_addr_q, csr_addr_d;
  logic [STRB_WIDTH-1:0] csr_strb_q, csr_strb_d;
  logic [DATA_WIDTH-1:0] csr_wdata_q, csr_wdata_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  busy_q, busy_d;
  logic                  grant;
  logic [DATA_WIDTH-1:0] resp;

  // Next-state and output-register logic. The per-requester rdata flops act
  // as the response register: they are loaded at the end of ACCESS only for
  // the winner and fall back to zero on every other cycle, so rdata is zero
  // whenever the matching ack is low.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    csr_cs_d     = 1'b0;
    csr_wen_d    = 1'b0;
    csr_addr_d   = csr_addr_q;
    csr_strb_d   = csr_strb_q;
    csr_wdata_d  = csr_wdata_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = '0;
    m1_rdata_d   = '0;
    grant        = 1'b0;
    resp         = '0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // Under contention the requester that did not win last time goes
          // first; otherwise the single pending requester wins.
          grant       = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
          winner_d    = grant;
          csr_cs_d    = 1'b1;
          csr_wen_d   = grant ? bus.m1_wen   : bus.m0_wen;
          csr_addr_d  = grant ? bus.m1_addr  : bus.m0_addr;
          csr_strb_d  = grant ? bus.m1_strb  : bus.m0_strb;
          csr_wdata_d = grant ? bus.m1_wdata : bus.m0_wdata;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        // csr_wen_q still holds the registered command type here.
        resp = csr_wen_q ? '0 : bus.csr_rdata;
        if (winner_q) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = resp;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = resp;
        end
        state_d = RESP;
      end

      RESP: begin
        last_grant_d = winner_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset restores the pointer to requester 1 so
  // requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      csr_cs_q     <= 1'b0;
      csr_wen_q    <= 1'b0;
      csr_addr_q   <= '0;
      csr_strb_q   <= '0;
      csr_wdata_q  <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      csr_cs_q     <= csr_cs_d;
      csr_wen_q    <= csr_wen_d;
      csr_addr_q   <= csr_addr_d;
      csr_strb_q   <= csr_strb_d;
      csr_wdata_q  <= csr_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.csr_cs    = csr_cs_q;
  assign bus.csr_wen   = csr_wen_q;
  assign bus.csr_addr  = csr_addr_q;
  assign bus.csr_strb  = csr_strb_q;
  assign bus.csr_wdata = csr_wdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_csr_bus_arbiter
// Drives both requester ports of csr_bus_arbiter and plays the CSR register
// file. A transaction-level reference model decides grant order, timing and
// read data; expected CSR commands and acks go into queues that a negedge
// monitor pops and compares as the DUT presents them.
// ----------------------------------------------------------------------------
module tb_csr_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    logic          wen;
    int            gap;
    bit            corrupt;
  } stim_t;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    int            due;
  } ackExp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    logic          wen;
    int            due;
  } csrExp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;

  stim_t   stimQ0[$];
  stim_t   stimQ1[$];
  ackExp_t ackQ[$];
  csrExp_t csrQ[$];

  logic [DW-1:0] csrMem [16];
  logic [DW-1:0] refMem [16];

  // Reference-model state: cycle label, round-robin pointer, next cycle the
  // arbiter can accept a new grant, and the cycle of the last grant.
  int cyc          = 0;
  bit ptr          = 1'b1;
  int nextFree     = 0;
  int lastGrantCyc = 0;
  bit hasGrant     = 1'b0;

  logic          drvReq   [2];
  logic [AW-1:0] drvAddr  [2];
  logic [SW-1:0] drvStrb  [2];
  logic [DW-1:0] drvWdata [2];
  logic          drvWen   [2];
  bit            active   [2];

  always #5 clk = ~clk;

  csr_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  csr_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  assign bus.m0_req   = drvReq[0];
  assign bus.m0_addr  = drvAddr[0];
  assign bus.m0_strb  = drvStrb[0];
  assign bus.m0_wdata = drvWdata[0];
  assign bus.m0_wen   = drvWen[0];
  assign bus.m1_req   = drvReq[1];
  assign bus.m1_addr  = drvAddr[1];
  assign bus.m1_strb  = drvStrb[1];
  assign bus.m1_wdata = drvWdata[1];
  assign bus.m1_wen   = drvWen[1];
  assign bus.csr_rdata = csrMem[bus.csr_addr[5:2]];

  function automatic logic [DW-1:0] memInit(int i);
    logic [DW-1:0] v;
    v = 32'h5A5A0000 ^ (32'(i) * 32'h00010203);
    if (i == 2) v = 32'hDEADBEEF;
    return v;
  endfunction

  function automatic logic [DW-1:0] mergeStrb(logic [DW-1:0] old, logic [DW-1:0] data,
                                             logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [AW-1:0] addr,
                               input logic [SW-1:0] strb, input logic [DW-1:0] wdata,
                               input logic wen, input int gap, input bit corrupt);
    stim_t s;
    s.addr = addr; s.strb = strb; s.wdata = wdata; s.wen = wen;
    s.gap = gap; s.corrupt = corrupt;
    if (id == 0) stimQ0.push_back(s);
    else         stimQ1.push_back(s);
  endtask

  task automatic waitDrain(input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (stimQ0.size() == 0 && stimQ1.size() == 0 && !active[0] && !active[1] &&
          ackQ.size() == 0 && csrQ.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", 64'(0), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  // Register-file model: combinational read above, byte-strobed write here.
  initial begin
    for (int i = 0; i < 16; i++) csrMem[i] = memInit(i);
    forever begin
      @(posedge clk);
      if (rstn && bus.csr_cs && bus.csr_wen)
        csrMem[bus.csr_addr[5:2]] = mergeStrb(csrMem[bus.csr_addr[5:2]],
                                              bus.csr_wdata, bus.csr_strb);
    end
  end

  // Requester driver: presents queued transactions at negedge, holds them
  // until ack, then either drops req or presents the next one immediately.
  initial begin
    stim_t s;
    int    gapCnt [2];
    bit    corruptPend [2];
    bit    ackSeen;
    for (int id = 0; id < 2; id++) begin
      drvReq[id] = 1'b0; drvAddr[id] = '0; drvStrb[id] = '0;
      drvWdata[id] = '0; drvWen[id] = 1'b0; active[id] = 1'b0;
      gapCnt[id] = 0; corruptPend[id] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        if (!rstn) begin
          active[id] = 1'b0;
          drvReq[id] = 1'b0;
          gapCnt[id] = 0;
          corruptPend[id] = 1'b0;
          continue;
        end
        ackSeen = (id == 0) ? bus.m0_ack : bus.m1_ack;
        if (active[id]) begin
          if (ackSeen) begin
            active[id] = 1'b0;
          end else if (corruptPend[id]) begin
            drvWdata[id] = ~drvWdata[id];
            corruptPend[id] = 1'b0;
          end
        end
        if (!active[id]) begin
          if ((id == 0 && stimQ0.size() > 0) || (id == 1 && stimQ1.size() > 0)) begin
            s = (id == 0) ? stimQ0[0] : stimQ1[0];
            if (gapCnt[id] < s.gap) begin
              drvReq[id] = 1'b0;
              gapCnt[id]++;
            end else begin
              if (id == 0) void'(stimQ0.pop_front());
              else         void'(stimQ1.pop_front());
              drvReq[id]   = 1'b1;
              drvAddr[id]  = s.addr;
              drvStrb[id]  = s.strb;
              drvWdata[id] = s.wdata;
              drvWen[id]   = s.wen;
              active[id]   = 1'b1;
              gapCnt[id]   = 0;
              corruptPend[id] = s.corrupt;
            end
          end else begin
            drvReq[id] = 1'b0;
          end
        end
      end
    end
  end

  // Reference model: a free arbiter grants at a rising edge, the command is
  // on the CSR port the following cycle and the ack one cycle after that;
  // the arbiter is free again three edges after a grant.
  initial begin
    int            win;
    logic [AW-1:0] a;
    logic [SW-1:0] st;
    logic [DW-1:0] wd;
    logic          we;
    logic [DW-1:0] expRdata;
    for (int i = 0; i < 16; i++) refMem[i] = memInit(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstn) begin
        ackQ.delete();
        csrQ.delete();
        ptr      = 1'b1;
        nextFree = 0;
        hasGrant = 1'b0;
      end else if (cyc >= nextFree && (bus.m0_req || bus.m1_req)) begin
        if (bus.m0_req && bus.m1_req) win = (ptr == 1'b0) ? 1 : 0;
        else                          win = bus.m0_req ? 0 : 1;
        a  = (win == 0) ? bus.m0_addr  : bus.m1_addr;
        st = (win == 0) ? bus.m0_strb  : bus.m1_strb;
        wd = (win == 0) ? bus.m0_wdata : bus.m1_wdata;
        we = (win == 0) ? bus.m0_wen   : bus.m1_wen;
        if (we) begin
          expRdata = '0;
          refMem[a[5:2]] = mergeStrb(refMem[a[5:2]], wd, st);
        end else begin
          expRdata = refMem[a[5:2]];
        end
        csrQ.push_back('{a, st, wd, we, cyc});
        ackQ.push_back('{win, expRdata, cyc + 1});
        ptr          = (win == 1);
        nextFree     = cyc + 3;
        lastGrantCyc = cyc;
        hasGrant     = 1'b1;
      end
    end
  end

  // Monitor: compares CSR commands, acks, idle-zero rules and busy.
  initial begin
    ackExp_t e;
    csrExp_t c;
    int      gotId;
    bit      busyExp;
    forever begin
      @(negedge clk);
      if (!rstn) continue;

      if (bus.m0_ack || bus.m1_ack) begin
        if (ackQ.size() == 0) begin
          checkOutput("unexpected_ack", 64'(1), 64'(0));
        end else begin
          e = ackQ.pop_front();
          gotId = bus.m1_ack ? 1 : 0;
          checkOutput("ack_id", 64'(gotId), 64'(e.id));
          checkOutput("ack_other", 64'((e.id == 1) ? bus.m0_ack : bus.m1_ack), 64'(0));
          checkOutput("ack_rdata", 64'((e.id == 1) ? bus.m1_rdata : bus.m0_rdata),
                      64'(e.rdata));
          checkOutput("ack_other_rdata", 64'((e.id == 1) ? bus.m0_rdata : bus.m1_rdata),
                      64'(0));
          checkOutput("ack_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        checkOutput("m0_rdata_idle", 64'(bus.m0_rdata), 64'(0));
        checkOutput("m1_rdata_idle", 64'(bus.m1_rdata), 64'(0));
        if (ackQ.size() > 0 && ackQ[0].due < cyc) begin
          checkOutput("ack_missing", 64'(0), 64'(1));
          void'(ackQ.pop_front());
        end
      end

      if (bus.csr_cs) begin
        if (csrQ.size() == 0) begin
          checkOutput("unexpected_csr_cs", 64'(1), 64'(0));
        end else begin
          c = csrQ.pop_front();
          checkOutput("csr_addr", 64'(bus.csr_addr), 64'(c.addr));
          checkOutput("csr_strb", 64'(bus.csr_strb), 64'(c.strb));
          checkOutput("csr_wdata", 64'(bus.csr_wdata), 64'(c.wdata));
          checkOutput("csr_wen", 64'(bus.csr_wen), 64'(c.wen));
          checkOutput("csr_cycle", 64'(cyc), 64'(c.due));
        end
      end else begin
        checkOutput("csr_wen_idle", 64'(bus.csr_wen), 64'(0));
        if (csrQ.size() > 0 && csrQ[0].due < cyc) begin
          checkOutput("csr_cs_missing", 64'(0), 64'(1));
          void'(csrQ.pop_front());
        end
      end

      busyExp = hasGrant && (cyc >= lastGrantCyc) && (cyc <= lastGrantCyc + 1);
      checkOutput("busy", 64'(bus.busy), 64'(busyExp));
    end
  end

  // Main sequence: reset, directed scenarios, random traffic, summary.
  initial begin
    bit seen;

    repeat (3) @(negedge clk);
    checkOutput("rst_csr_cs", 64'(bus.csr_cs), 64'(0));
    checkOutput("rst_csr_wen", 64'(bus.csr_wen), 64'(0));
    checkOutput("rst_csr_addr", 64'(bus.csr_addr), 64'(0));
    checkOutput("rst_csr_strb", 64'(bus.csr_strb), 64'(0));
    checkOutput("rst_csr_wdata", 64'(bus.csr_wdata), 64'(0));
    checkOutput("rst_m0_ack", 64'(bus.m0_ack), 64'(0));
    checkOutput("rst_m1_ack", 64'(bus.m1_ack), 64'(0));
    checkOutput("rst_m0_rdata", 64'(bus.m0_rdata), 64'(0));
    checkOutput("rst_m1_rdata", 64'(bus.m1_rdata), 64'(0));
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Single read by m0 of the word holding 0xDEADBEEF.
    applyStimulus(0, 16'h0008, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    waitDrain(50);

    // Single write by m1.
    applyStimulus(1, 16'h0004, 4'b0011, 32'h00000A5F, 1'b1, 0, 1'b0);
    waitDrain(50);

    // Contention with continuous back-to-back reads from both requesters.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 16'(i * 4), 4'hF, 32'h0, 1'b0, 0, 1'b0);
      applyStimulus(1, 16'((i + 8) * 4), 4'hF, 32'h0, 1'b0, 0, 1'b0);
    end
    waitDrain(100);

    // m1 arrives one cycle after m0 is granted.
    applyStimulus(0, 16'h0010, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    applyStimulus(1, 16'h0014, 4'hF, 32'h0, 1'b0, 1, 1'b0);
    waitDrain(50);

    // m0 changes wdata after grant; the registered value must be used.
    applyStimulus(0, 16'h0014, 4'hF, 32'h12345678, 1'b1, 0, 1'b1);
    applyStimulus(0, 16'h0014, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    waitDrain(50);

    // Reset during ACCESS of an m0 read.
    applyStimulus(0, 16'h0018, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.csr_cs) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("midop_access_seen", 64'(seen), 64'(1));
    #2 rstn = 1'b0;
    #1;
    checkOutput("midop_csr_cs", 64'(bus.csr_cs), 64'(0));
    checkOutput("midop_busy", 64'(bus.busy), 64'(0));
    checkOutput("midop_m0_ack", 64'(bus.m0_ack), 64'(0));
    checkOutput("midop_m1_ack", 64'(bus.m1_ack), 64'(0));
    checkOutput("midop_csr_addr", 64'(bus.csr_addr), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Pointer back at 1: m0 must win this contention first.
    applyStimulus(0, 16'h001C, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    applyStimulus(1, 16'h0020, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    waitDrain(50);

    // m1-only request after reset.
    applyStimulus(1, 16'h0024, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    waitDrain(50);

    // Random traffic from both requesters.
    for (int i = 0; i < 40; i++) begin
      for (int id = 0; id < 2; id++) begin
        applyStimulus(id, 16'($urandom_range(0, 15)) << 2, 4'($urandom_range(0, 15)),
                      $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
      end
    end
    waitDrain(2000);

    checkOutput("leftover_ack", 64'(ackQ.size()), 64'(0));
    checkOutput("leftover_csr", 64'(csrQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
